// File: rtl/gpu_raster_pkg.sv
// gpu_raster_pkg: shared state/mode types, default widths and beat-count helper for the rectangle rasteriser
`ifndef WIDTH_BITS
`define WIDTH_BITS 8
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 8
`endif
package gpu_raster_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic {MODE_FILL, MODE_OUTLINE} mode_e;
  function automatic int beat_count(input int xmin, input int xmax, input int ymin, input int ymax,
                                    input mode_e mode, input int lanes);
    int spans;
    int rows;
    spans = (xmax - xmin + lanes) / lanes;
    rows = ymax - ymin + 1;
    if (mode == MODE_FILL || rows == 1) return rows * spans;
    return 2 * spans + (rows - 2) * ((xmin == xmax) ? 1 : 2);
  endfunction
endpackage

// File: rtl/gpu_rect_raster_if.sv
// gpu_rect_raster_if: command and pixel-beat handshake bundle between decoder, rasteriser and write arbiter
interface gpu_rect_raster_if #(
  parameter int X_BITS = `WIDTH_BITS,
  parameter int Y_BITS = `HEIGHT_BITS,
  parameter int LANES  = 4
);
  logic [X_BITS-1:0] x1_i, x2_i, x_o;
  logic [Y_BITS-1:0] y1_i, y2_i, y_o;
  logic              mode_i, start_i, abort_i, ready_i;
  logic              valid_o, busy_o, done_o;
  logic [LANES-1:0]  mask_o;
  modport master (
    output x1_i, x2_i, y1_i, y2_i, mode_i, start_i, abort_i, ready_i,
    input  valid_o, x_o, y_o, mask_o, busy_o, done_o
  );
  modport slave (
    input  x1_i, x2_i, y1_i, y2_i, mode_i, start_i, abort_i, ready_i,
    output valid_o, x_o, y_o, mask_o, busy_o, done_o
  );
endinterface

// File: rtl/gpu_raster_span_mask.sv
// gpu_raster_span_mask: lane mask for a beat, clipped at xmax or reduced to lane 0 for outline edge pixels
module gpu_raster_span_mask #(
  parameter int X_BITS = 8,
  parameter int LANES  = 4
) (
  input  logic [X_BITS:0]   x_i,
  input  logic [X_BITS:0]   xmax_i,
  input  logic              single_i,
  output logic [LANES-1:0]  mask_o
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign mask_o[i] = single_i ? (i == 0) : (x_i + (X_BITS+1)'(i) <= xmax_i);
  end
endmodule

// File: rtl/gpu_rect_raster.sv
// gpu_rect_raster: walks a latched rectangle as LANES-wide pixel beats in fill or outline mode
module gpu_rect_raster
  import gpu_raster_pkg::*;
#(
  parameter int X_BITS = `WIDTH_BITS,
  parameter int Y_BITS = `HEIGHT_BITS,
  parameter int LANES  = 4
) (
  input logic clk,
  input logic n_rst,
  gpu_rect_raster_if.slave bus
);
  localparam int XW = X_BITS + 1;
  localparam int YW = Y_BITS + 1;
  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [XW-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d, x_step;
  logic [YW-1:0]     ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
  logic [X_BITS-1:0] xlo, xhi;
  logic [Y_BITS-1:0] ylo, yhi;
  logic              interior, row_end;
  logic [LANES-1:0]  span;
  always_comb begin
    xlo = (bus.x1_i < bus.x2_i) ? bus.x1_i : bus.x2_i;
    xhi = (bus.x1_i < bus.x2_i) ? bus.x2_i : bus.x1_i;
    ylo = (bus.y1_i < bus.y2_i) ? bus.y1_i : bus.y2_i;
    yhi = (bus.y1_i < bus.y2_i) ? bus.y2_i : bus.y1_i;
    interior = mode_q == MODE_OUTLINE && y_q != ymin_q && y_q != ymax_q;
    x_step = interior ? xmax_q : x_q + XW'(LANES);
    row_end = interior ? x_q == xmax_q : x_step > xmax_q;
  end
  // Interior outline rows visit only xmin then xmax, so row_end there is "reached xmax".
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    x_d = x_q;
    y_d = y_q;
    if (state_q == IDLE && bus.start_i) begin
      state_d = RUN;
      mode_d = bus.mode_i ? MODE_OUTLINE : MODE_FILL;
      xmin_d = {1'b0, xlo};
      xmax_d = {1'b0, xhi};
      ymin_d = {1'b0, ylo};
      ymax_d = {1'b0, yhi};
      x_d = {1'b0, xlo};
      y_d = {1'b0, ylo};
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      if (bus.abort_i) state_d = IDLE;
      else if (bus.ready_i) begin
        if (!row_end) x_d = x_step;
        else if (y_q == ymax_q) state_d = DONE;
        else begin
          x_d = xmin_q;
          y_d = y_q + YW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      mode_q <= MODE_FILL;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  gpu_raster_span_mask #(.X_BITS(X_BITS), .LANES(LANES)) u_mask (
    .x_i(x_q),
    .xmax_i(xmax_q),
    .single_i(interior),
    .mask_o(span)
  );
  assign bus.valid_o = state_q == RUN;
  assign bus.busy_o = state_q == RUN;
  assign bus.done_o = state_q == DONE;
  assign bus.x_o = x_q[X_BITS-1:0];
  assign bus.y_o = y_q[Y_BITS-1:0];
  assign bus.mask_o = (state_q == RUN) ? span : '0;
endmodule

// File: tb/tb_gpu_rect_raster.sv
// tb_gpu_rect_raster: directed scoreboard bench; stimulus queues expected beats, a negedge monitor checks them
module tb_gpu_rect_raster;
  import gpu_raster_pkg::*;
  typedef struct {int x; int y; int m;} beat_t;
  logic clk = 0;
  logic n_rst = 0;
  int checks = 0;
  int failures = 0;
  int accepted = 0;
  beat_t exp_q[$];
  logic held = 0;
  logic done_pending = 0;
  beat_t held_b;
  gpu_rect_raster_if #(.X_BITS(8), .Y_BITS(8), .LANES(4)) bus ();
  gpu_rect_raster #(.X_BITS(8), .Y_BITS(8), .LANES(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
    end
  endtask
  task automatic push(input int x, input int y, input int m);
    beat_t b;
    b.x = x;
    b.y = y;
    b.m = m;
    exp_q.push_back(b);
  endtask
  task automatic push_fill06();
    for (int y = 0; y <= 6; y++) begin
      push(0, y, 4'b1111);
      push(4, y, 4'b0011);
    end
  endtask
  always @(negedge clk) begin
    if (!n_rst) begin
      held = 0;
      done_pending = 0;
    end else begin
      logic done_now;
      done_now = done_pending;
      done_pending = 0;
      if (bus.done_o || done_now) chk("done_pulse", int'(bus.done_o), int'(done_now));
      if (held && bus.valid_o) begin
        chk("stall_x", int'(bus.x_o), held_b.x);
        chk("stall_y", int'(bus.y_o), held_b.y);
        chk("stall_mask", int'(bus.mask_o), held_b.m);
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_x", int'(bus.x_o), b.x);
          chk("beat_y", int'(bus.y_o), b.y);
          chk("beat_mask", int'(bus.mask_o), b.m);
          if (exp_q.size() == 0 && !bus.abort_i) done_pending = 1;
        end
        accepted++;
      end
      held = bus.valid_o && !bus.ready_i && !bus.abort_i;
      held_b.x = int'(bus.x_o);
      held_b.y = int'(bus.y_o);
      held_b.m = int'(bus.mask_o);
    end
  end
  task automatic kick(input int x1, input int y1, input int x2, input int y2, input logic m);
    accepted = 0;
    @(posedge clk);
    #1;
    bus.x1_i = 8'(x1);
    bus.y1_i = 8'(y1);
    bus.x2_i = 8'(x2);
    bus.y2_i = 8'(y2);
    bus.mode_i = m;
    bus.start_i = 1;
    bus.ready_i = 1;
    @(posedge clk);
    #1;
    bus.start_i = 0;
    chk("busy_after_start", int'(bus.busy_o), 1);
    chk("valid_after_start", int'(bus.valid_o), 1);
  endtask
  task automatic finish_rect(input int n, input bit rnd);
    for (int c = 0; c < 400 && !bus.done_o; c++) begin
      bus.ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
    end
    chk("done_seen", int'(bus.done_o), 1);
    chk("beat_total", accepted, n);
    chk("queue_empty", exp_q.size(), 0);
    bus.ready_i = 1;
    @(posedge clk);
    #1;
    chk("idle_after_done", int'({bus.busy_o, bus.valid_o, bus.done_o}), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.x1_i = 0; bus.x2_i = 0; bus.y1_i = 0; bus.y2_i = 0;
    bus.mode_i = 0; bus.start_i = 0; bus.abort_i = 0; bus.ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({bus.valid_o, bus.busy_o, bus.done_o, bus.x_o, bus.y_o, bus.mask_o}), 0);
    n_rst = 1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", int'(bus.valid_o), 0);
    chk("fn_fill", beat_count(0, 5, 0, 6, MODE_FILL, 4), 14);
    chk("fn_outline", beat_count(2, 9, 1, 4, MODE_OUTLINE, 4), 8);
    chk("fn_thin", beat_count(3, 3, 0, 3, MODE_OUTLINE, 4), 4);
    // fill (0,0)-(5,6), then the same rectangle with swapped corners
    push_fill06();
    kick(0, 0, 5, 6, 0);
    finish_rect(14, 0);
    push_fill06();
    kick(5, 6, 0, 0, 0);
    finish_rect(14, 0);
    // outline (2,1)-(9,4)
    for (int y = 1; y <= 4; y++) begin
      if (y == 1 || y == 4) begin
        push(2, y, 4'b1111);
        push(6, y, 4'b1111);
      end else begin
        push(2, y, 4'b0001);
        push(9, y, 4'b0001);
      end
    end
    kick(9, 4, 2, 1, 1);
    finish_rect(8, 0);
    // one-pixel-wide outline: interior rows emit only the xmin beat
    for (int y = 0; y <= 3; y++) push(3, y, 4'b0001);
    kick(3, 0, 3, 3, 1);
    finish_rect(4, 0);
    // random backpressure on the fill scenario
    push_fill06();
    kick(0, 0, 5, 6, 0);
    finish_rect(14, 1);
    // abort after three accepted beats
    push_fill06();
    kick(0, 0, 5, 6, 0);
    for (int c = 0; c < 50 && accepted < 3; c++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_accepted", accepted, 3);
    bus.ready_i = 0;
    bus.abort_i = 1;
    @(posedge clk);
    #1;
    bus.abort_i = 0;
    bus.ready_i = 1;
    exp_q.delete();
    chk("abort_valid", int'(bus.valid_o), 0);
    chk("abort_busy", int'(bus.busy_o), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", int'(bus.done_o), 0);
    end
    push(1, 1, 4'b0001);
    kick(1, 1, 1, 1, 0);
    finish_rect(1, 0);
    // right-edge column: no wrap past 2^X_BITS-1
    for (int y = 10; y <= 12; y++) push(255, y, 4'b0001);
    kick(255, 10, 255, 12, 0);
    finish_rect(3, 0);
    // asynchronous reset mid-run
    push_fill06();
    kick(0, 0, 5, 6, 0);
    @(posedge clk);
    #1;
    n_rst = 0;
    #1;
    chk("midrun_rst_outputs", int'({bus.valid_o, bus.busy_o, bus.done_o, bus.x_o, bus.y_o, bus.mask_o}), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    n_rst = 1;
    push(1, 1, 4'b0001);
    kick(1, 1, 1, 1, 0);
    finish_rect(1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpu_rect_raster.md
# gpu_rect_raster

Parametrised rectangle rasteriser, successor to the single-pixel fill-rect walker. It takes two corner coordinates and emits the covered pixels as multi-pixel beats (LANES pixels per beat, with a lane mask), in either filled or outline mode. Output uses a ready/valid handshake so the framebuffer write path can apply backpressure. It sits between the GPU command decoder and the pixel write arbiter.

## Interface
Parameters:
- X_BITS, default `WIDTH_BITS: x coordinate width
- Y_BITS, default `HEIGHT_BITS: y coordinate width
- LANES, default 4: pixels per beat; power of two, 1..16

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- x1_i, x2_i  in  X_BITS  corner x coordinates, any order
- y1_i, y2_i  in  Y_BITS  corner y coordinates, any order
- mode_i  in  1  0 = fill, 1 = outline
- start_i  in  1  sampled only in IDLE; latches corners and mode
- abort_i  in  1  cancels the current rectangle
- ready_i  in  1  downstream accepts the current beat
- valid_o  out  1  beat present
- x_o  out  X_BITS  x of lane 0
- y_o  out  Y_BITS  row of the beat
- mask_o  out  LANES  bit i set means pixel (x_o+i, y_o) is written
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start_i=1, latch xmin=min(x1,x2), xmax=max, ymin, ymax and mode; go to RUN.
- RUN: valid_o=1. A beat completes on valid_o&ready_i. While ready_i=0, x_o, y_o and mask_o stay stable.
- Fill: rows ymin..ymax, top to bottom. Within a row, beats start at xmin and step by LANES. Bit i of mask_o = (x_o+i <= xmax).
- Outline: rows ymin and ymax are emitted exactly as in fill.
  - Each interior row emits beat (xmin, mask=...0001), then beat (xmax, mask=...0001).
  - If xmin==xmax, an interior row emits only the single xmin beat.
- If ymin==ymax, there is a single row in both modes.
- After the last beat completes, go to DONE. DONE lasts one cycle with done_o=1, then returns to IDLE.
- abort_i=1 in RUN: go to IDLE on the next edge.
  - valid_o drops the following cycle; no done_o.
  - A beat handshaken in the same cycle counts as accepted.
  - abort_i is ignored in IDLE and DONE.
- start_i is ignored in RUN and DONE.
- Reset (asynchronous, any state): return to IDLE. Any in-flight rectangle is discarded and no done_o is issued.

## Timing
- Reset values: valid_o=0, busy_o=0, done_o=0, x_o=0, y_o=0, mask_o=0.
- start_i sampled at edge N: valid_o=1 and busy_o=1 during cycle N+1, with the first beat at (xmin, ymin).
- Throughput: one beat per cycle while ready_i=1; no bubbles between rows.
- Fill beat count: (ymax-ymin+1) * ceil((xmax-xmin+1)/LANES).
- done_o is high in the cycle after the final handshake. The next start_i is accepted at the edge following done_o.
- Width rule: next-x and the mask compare use X_BITS+1 bits, so xmax near 2^X_BITS-1 does not wrap.
- Width rule: the row counter likewise uses Y_BITS+1 bits.

## Structure
- Package gpu_raster_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - mode enum {MODE_FILL, MODE_OUTLINE}
  - a function returning the beat count, shared with the bench
- Sub-module gpu_raster_span_mask is combinational. Inputs: x_o and xmax (X_BITS+1) plus a single-pixel flag. Output: mask_o.
- FSM, corner latch and x/y counters live in the top module.

## Test plan
- LANES=4, fill (0,0)-(5,6), ready_i=1 → 14 consecutive beats.
  - Beats alternate x_o=0 mask 1111 and x_o=4 mask 0011, for y=0..6.
  - done_o pulses one cycle after beat 14.
- Swapped corners (5,6)-(0,0) → beat stream identical to the previous scenario.
- Outline (2,1)-(9,4), LANES=4:
  - Rows 1 and 4: x=2/1111, x=6/1111, then x=10 with mask all zero? No — x=10 is not emitted, because the span ends at x=9: beats are x=2/1111, x=6/1111.
  - Rows 2 and 3: x=2/0001, then x=9/0001.
  - 8 beats total.
- Backpressure: random ready_i on the first scenario → outputs stay stable while ready_i=0; accepted stream equals the first scenario; no beat lost or duplicated.
- Abort after 3 accepted beats → valid_o low the next cycle, busy_o=0, done_o never asserted. A new start_i of (1,1)-(1,1) then yields one beat x=1, y=1, mask 0001.
- Edge corner x1=x2=2^X_BITS-1, LANES=4 → one beat per row with mask 0001; no x wrap. Also assert n_rst mid-RUN → all outputs return to zero immediately.
